// File: rtl/i2c_target_rx.sv
// I2C target write receiver: START/STOP detection, 7-bit address match,
// byte reception with ACK/NACK and a valid/ready byte output.
module i2c_target_rx #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [2:0] {
        k_idle,
        k_addr,
        k_addr_ack,
        k_data,
        k_data_ack,
        k_ignore
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic byte_done, addr_hit, hold;

    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n, sda_oe_n, busy_n, overrun_n;

    // Synchronisers idle high so reset looks like a released bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;
    assign byte_done = scl_fall & (bit_cnt == 4'd8);
    assign addr_hit  = (shift[7:1] == ADDR) & ~shift[0];
    // A consume on this clk frees the holding register for the ACK decision
    assign hold      = rx_valid & ~rx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= k_idle;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (start_det) begin
            state_n = k_addr;
        end else if (stop_det) begin
            state_n = k_idle;
        end else begin
            unique case (state)
                k_addr:
                    if (byte_done)
                        state_n = addr_hit ? k_addr_ack : k_ignore;
                k_addr_ack:
                    if (scl_fall) state_n = k_data;
                k_data:
                    if (byte_done) state_n = k_data_ack;
                k_data_ack:
                    if (scl_fall) state_n = k_data;
                default:
                    state_n = state;
            endcase
        end
    end

    always_comb begin
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        rx_data_n  = rx_data;
        rx_valid_n = hold;
        sda_oe_n   = sda_oe;
        busy_n     = busy;
        overrun_n  = 1'b0;
        if (start_det) begin
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (stop_det) begin
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else begin
            unique case (state)
                k_addr, k_data: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n   = {shift[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                    if (byte_done) begin
                        if (state == k_addr) begin
                            sda_oe_n = addr_hit;
                        end else if (!hold) begin
                            rx_data_n  = shift;
                            rx_valid_n = 1'b1;
                            sda_oe_n   = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            overrun_n = 1'b1;
                        end
                    end
                end
                k_addr_ack:
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        busy_n    = 1'b1;
                        bit_cnt_n = 4'd0;
                    end
                k_data_ack:
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = 4'd0;
                    end
                default:
                    sda_oe_n = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            sda_oe   <= sda_oe_n;
            busy     <= busy_n;
            overrun  <= overrun_n;
        end
    end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- I2C target (slave) receiver: the far end of the bus that our I2C master transmitter drives.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, shifts in write-data bytes MSB-first and drives ACK/NACK on SDA.
- Hands each received byte to the fabric through a valid/ready handshake. Read transfers are not acknowledged.

Parameters:
- ADDR, 7'h42, 7-bit target address this block responds to.
- SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in (minimum 2).

Ports:
- clk  in  1  system clock; must be ≥ 8x the SCL frequency.
- reset  in  1  asynchronous, active-high reset.
- scl_in  in  1  raw SCL pad input.
- sda_in  in  1  raw SDA pad input.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- rx_data  out  8  last accepted byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- busy  out  1  high from address match until STOP or repeated START.
- overrun  out  1  one-clk pulse when a byte is NACKed because rx_valid was still high.

Behaviour:
- Reset values (async, immediate): sda_oe=0, rx_data=8'h00, rx_valid=0, busy=0, overrun=0, state=k_idle, bit counter=0, shift register=0. Synchroniser flops reset to 1 (idle bus).
- Input conditioning: scl_s/sda_s are SYNC_STAGES-flop synchronised, plus one extra registered copy for edge detection.
  - scl_rise/scl_fall: edges of scl_s.
  - START: sda_s falls while scl_s is high.
  - STOP: sda_s rises while scl_s is high.
- Sampling: data bits are shifted in on scl_rise. SDA changes are evaluated as START/STOP only while SCL is high.
- START (from any state, including a repeated START mid-byte): go to k_addr, clear bit counter, sda_oe=0, busy=0.
- STOP (from any state): go to k_idle, sda_oe=0, busy=0. rx_valid and rx_data are unaffected.
- States:
  - k_idle: wait for START.
  - k_addr: shift 8 bits on scl_rise. On the scl_fall after the 8th bit:
    - shift[7:1]==ADDR and shift[0]==0 (write): sda_oe=1, go to k_addr_ack.
    - otherwise: sda_oe=0, go to k_ignore.
  - k_addr_ack: on next scl_fall, sda_oe=0, busy=1, go to k_data, bit counter=0.
  - k_data: shift 8 bits on scl_rise. On the scl_fall after the 8th bit:
    - rx_valid==0: rx_data<=shift, rx_valid<=1, sda_oe=1 (ACK).
    - rx_valid==1: sda_oe=0 (NACK), overrun pulses one clk, byte dropped.
    - Either way, go to k_data_ack.
  - k_data_ack: on next scl_fall, sda_oe=0, go to k_data. The master may continue after a NACK; subsequent bytes are evaluated independently.
  - k_ignore: sda_oe held 0; wait for START/STOP.
- Handshake:
  - rx_valid clears on the clk where rx_valid && rx_ready.
  - If a consume and a new byte load occur on the same clk, rx_valid is already cleared for the ACK decision. That is, rx_ready is evaluated first and the new byte is ACKed and loaded.
  - rx_data is stable while rx_valid=1.
- Bit counter: 4-bit, counts 0..8. It does not wrap within a byte; it clears on entry to k_addr and k_data.
- sda_oe changes only on scl_fall (clk after the detected edge) or on START/STOP/reset. It is never asserted while scl_s is high, except when held through the ACK bit.
- Reset asserted mid-transfer: all outputs return to reset values immediately. The bus is released, and the block re-arms on the next START.

Test Plan:
- Write to 0x42 (address byte 8'h84) then data 8'hA5, rx_ready=1 → sda_oe=1 during both 9th bits; rx_data=8'hA5 with a single rx_valid pulse; busy=1 until STOP, then busy=0.
- Address byte 8'h86 (wrong address 0x43) then data 8'h5A → sda_oe stays 0 throughout; rx_valid never set; state k_ignore until STOP.
- Address byte 8'h85 (read to 0x42) → NACK (sda_oe=0 on the 9th bit); no rx_valid.
- Write 0x42 with bytes 8'h11, 8'h22 and rx_ready=0 → first byte ACKed, rx_data=8'h11; second byte NACKed, overrun pulses once, rx_data remains 8'h11.
- Repeated START after 4 data bits, then address byte 8'h84 and data 8'h3C → partial byte discarded; new address ACKed; rx_data=8'h3C.
- Assert reset while sda_oe=1 during an ACK → sda_oe=0, rx_valid=0, busy=0 on the same clk. After release, a full write of 8'h77 is received correctly.
